sobel_core: RTL

Pipelined Sobel gradient stage that consumes the eight 3x3 neighbourhood pixels produced by the image-input stage each pixel clock. It outputs a saturated 8-bit edge magnitude and a thresholded edge bit, and keeps a per-frame edge-pixel count. It sits between the neighbourhood fetch and the display/output formatter.

---
 rtl/sobel_core.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_core.sv
// sobel_core: three-stage pipelined Sobel gradient.
//   stage 1 : four unsigned 10-bit partial sums of the 3x3 neighbourhood
//   stage 2 : |Gx| and |Gy| as (larger sum - smaller sum), unsigned
//   stage 3 : saturated magnitude, threshold compare, border masking
// A per-frame edge-pixel counter runs off the stage-3 registers. It reports
// the previous frame's count one cycle after each out_sof.
// The threshold-exceeded output is named edge_flag because "edge" is a
// reserved word in SystemVerilog.

module sobel_core #(
    parameter int COUNT_W = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  logic               in_border,
    input  logic               sof,
    input  logic [7:0]         pix_0,
    input  logic [7:0]         pix_1,
    input  logic [7:0]         pix_2,
    input  logic [7:0]         pix_3,
    input  logic [7:0]         pix_5,
    input  logic [7:0]         pix_6,
    input  logic [7:0]         pix_7,
    input  logic [7:0]         pix_8,
    input  logic [7:0]         thresh,
    output logic [7:0]         mag,
    output logic               edge_flag,
    output logic               out_vld,
    output logic               out_sof,
    output logic [COUNT_W-1:0] edge_count,
    output logic               count_vld
);

    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    // Unsigned |a - b| without signed arithmetic: larger minus smaller.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Weighted sum p_a + 2*p_b + p_c, at most 1020, so it fits in 10 bits.
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: partial sums
    // ------------------------------------------------------------------
    logic [9:0] gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
    logic [9:0] gx_pos_r, gx_neg_r, gy_pos_r, gy_neg_r;
    logic       s1_vld_r, s1_border_r, s1_sof_r;

    // Combinational partial sums of the incoming neighbourhood.
    always_comb begin
        gx_pos_s = wsum(pix_2, pix_5, pix_8);
        gx_neg_s = wsum(pix_0, pix_3, pix_6);
        gy_pos_s = wsum(pix_6, pix_7, pix_8);
        gy_neg_s = wsum(pix_0, pix_1, pix_2);
    end

    // Stage-1 register. The sums load only on valid inputs, and a bubble
    // passes through as s1_vld_r = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r    <= 1'b0;
            s1_border_r <= 1'b0;
            s1_sof_r    <= 1'b0;
            gx_pos_r    <= 10'd0;
            gx_neg_r    <= 10'd0;
            gy_pos_r    <= 10'd0;
            gy_neg_r    <= 10'd0;
        end else begin
            s1_vld_r    <= in_vld;
            s1_border_r <= in_border;
            s1_sof_r    <= sof & in_vld;
            if (in_vld) begin
                gx_pos_r <= gx_pos_s;
                gx_neg_r <= gx_neg_s;
                gy_pos_r <= gy_pos_s;
                gy_neg_r <= gy_neg_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: absolute gradients
    // ------------------------------------------------------------------
    logic [9:0] gx_abs_s, gy_abs_s;
    logic [9:0] gx_abs_r, gy_abs_r;
    logic       s2_vld_r, s2_border_r, s2_sof_r;

    // Absolute gradient per axis.
    always_comb begin
        gx_abs_s = abs_diff(gx_pos_r, gx_neg_r);
        gy_abs_s = abs_diff(gy_pos_r, gy_neg_r);
    end

    // Stage-2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r    <= 1'b0;
            s2_border_r <= 1'b0;
            s2_sof_r    <= 1'b0;
            gx_abs_r    <= 10'd0;
            gy_abs_r    <= 10'd0;
        end else begin
            s2_vld_r    <= s1_vld_r;
            s2_border_r <= s1_border_r;
            s2_sof_r    <= s1_sof_r;
            if (s1_vld_r) begin
                gx_abs_r <= gx_abs_s;
                gy_abs_r <= gy_abs_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, threshold, border mask
    // ------------------------------------------------------------------
    logic [10:0] grad_sum_s;
    logic [7:0]  mag_s;
    logic        edge_s;
    logic [7:0]  mag_r;
    logic        edge_r, out_vld_r, out_sof_r;

    // Saturate |Gx|+|Gy| to 8 bits and compare against the live threshold.
    // Border neighbourhoods are forced to a non-edge zero.
    always_comb begin
        grad_sum_s = {1'b0, gx_abs_r} + {1'b0, gy_abs_r};
        mag_s      = 8'd0;
        edge_s     = 1'b0;
        if (s2_border_r) begin
            mag_s  = 8'd0;
            edge_s = 1'b0;
        end else begin
            if (grad_sum_s > 11'd255) begin
                mag_s = 8'd255;
            end else begin
                mag_s = grad_sum_s[7:0];
            end
            edge_s = (mag_s >= thresh);
        end
    end

    // Output register. mag/edge hold their values through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_r     <= 8'd0;
            edge_r    <= 1'b0;
            out_vld_r <= 1'b0;
            out_sof_r <= 1'b0;
        end else begin
            out_vld_r <= s2_vld_r;
            out_sof_r <= s2_sof_r;
            if (s2_vld_r) begin
                mag_r  <= mag_s;
                edge_r <= edge_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame edge counter
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0] cnt_r, cnt_s;
    logic [COUNT_W-1:0] edge_count_r, edge_count_s;
    logic               count_vld_r, count_vld_s;
    logic               seen_r, seen_s;
    logic               frame_close_s;

    // A valid out_sof closes the running frame: its count is reported if an
    // earlier frame was opened, and the counter restarts from the current
    // pixel's edge bit. Otherwise the counter saturates on valid edge pixels.
    always_comb begin
        frame_close_s = out_vld_r & out_sof_r;
        cnt_s         = cnt_r;
        edge_count_s  = edge_count_r;
        count_vld_s   = 1'b0;
        seen_s        = seen_r;
        if (frame_close_s) begin
            if (seen_r) begin
                edge_count_s = cnt_r;
                count_vld_s  = 1'b1;
            end else begin
                edge_count_s = edge_count_r;
                count_vld_s  = 1'b0;
            end
            if (edge_r) begin
                cnt_s = CNT_ONE;
            end else begin
                cnt_s = CNT_ZERO;
            end
            seen_s = 1'b1;
        end else if (out_vld_r && edge_r) begin
            if (cnt_r != CNT_MAX) begin
                cnt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Counter, report register and frame-seen flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= CNT_ZERO;
            edge_count_r <= CNT_ZERO;
            count_vld_r  <= 1'b0;
            seen_r       <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            edge_count_r <= edge_count_s;
            count_vld_r  <= count_vld_s;
            seen_r       <= seen_s;
        end
    end

    assign mag        = mag_r;
    assign edge_flag  = edge_r;
    assign out_vld    = out_vld_r;
    assign out_sof    = out_sof_r;
    assign edge_count = edge_count_r;
    assign count_vld  = count_vld_r;

endmodule
